// File: rtl/game_man_move_if.sv
// ---------------------------------------------------------------------------
// game_man_move_if
// Bundles the move-engine data path between the game controller (master) and
// the move engine (slave).
//   game_state       controller -> engine  {floor[63:0], box[63:0], man_row, man_col}
//   cursor           controller -> engine  {cur_row, cur_col} step target
//   game_state_next  engine -> controller  board after one step, same packing
//   result           engine -> controller  1 = man moved this evaluation
// ---------------------------------------------------------------------------
interface game_man_move_if;
    logic [133:0] game_state;
    logic [5:0]   cursor;
    logic [133:0] game_state_next;
    logic         result;

    modport master (
        output game_state,
        output cursor,
        input  game_state_next,
        input  result
    );

    modport slave (
        input  game_state,
        input  cursor,
        output game_state_next,
        output result
    );
endinterface

// File: rtl/game_man_move.sv
// ---------------------------------------------------------------------------
// game_man_move
// Sokoban move engine. Each clock it takes the packed board and a cursor,
// moves the man one cell toward the cursor (horizontal first, vertical as a
// fallback), pushing at most one box, and registers the resulting board.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset; clears the registered outputs
//   bus   game_man_move_if.slave: game_state/cursor in,
//         game_state_next/result out (1 clock latency)
// ---------------------------------------------------------------------------
module game_man_move (
    input  logic            clk,
    input  logic            rst,
    game_man_move_if.slave  bus
);

    typedef struct packed {
        logic         ok;
        logic [133:0] st;
    } step_t;

    // Unit step (-1/0/+1) in the direction of a signed coordinate delta.
    function automatic logic signed [3:0] unit_dir(input logic signed [3:0] d);
        if (d == 4'sd0)
            return 4'sd0;
        else if (d[3])
            return -4'sd1;
        else
            return 4'sd1;
    endfunction

    // Attempt one step of the man by (dr, dc). A zero direction is an absent
    // move and never succeeds. Coordinates use 4-bit signed values so that a
    // step off either grid edge sets bit 3 instead of wrapping.
    function automatic step_t try_step(input logic [133:0]      st,
                                       input logic signed [3:0] dr,
                                       input logic signed [3:0] dc);
        step_t             res;
        logic [63:0]       fl;
        logic [63:0]       bx;
        logic signed [3:0] mr;
        logic signed [3:0] mc;
        logic signed [3:0] tr;
        logic signed [3:0] tc;
        logic signed [3:0] br;
        logic signed [3:0] bc;
        logic [5:0]        ti;
        logic [5:0]        bi;
        logic              t_on;
        logic              b_on;

        res.ok = 1'b0;
        res.st = st;
        fl     = st[133:70];
        bx     = st[69:6];
        mr     = $signed({1'b0, st[5:3]});
        mc     = $signed({1'b0, st[2:0]});
        tr     = mr + dr;
        tc     = mc + dc;
        br     = tr + dr;
        bc     = tc + dc;
        ti     = {tr[2:0], tc[2:0]};
        bi     = {br[2:0], bc[2:0]};
        t_on   = !tr[3] && !tc[3] && !((dr == 4'sd0) && (dc == 4'sd0));
        b_on   = !br[3] && !bc[3];

        if (t_on) begin
            if (fl[ti] && !bx[ti]) begin
                res.ok     = 1'b1;
                res.st[5:0] = ti;
            end else if (!fl[ti] && bx[ti] && b_on && fl[bi] && !bx[bi]) begin
                // Push: the vacated box cell becomes floor, the target
                // cell beyond becomes a box.
                fl[ti] = 1'b1;
                bx[ti] = 1'b0;
                fl[bi] = 1'b0;
                bx[bi] = 1'b1;
                res.ok = 1'b1;
                res.st = {fl, bx, ti};
            end
        end
        return res;
    endfunction

    logic signed [3:0] dr_p0;
    logic signed [3:0] dc_p0;
    step_t             prim_p0;
    step_t             sec_p0;
    logic [133:0]      state_p0;
    logic              result_p0;
    logic [133:0]      state_p1;
    logic              result_p1;

    // ---- stage p0: direction choice and step evaluation ----
    assign dr_p0 = $signed({1'b0, bus.cursor[5:3]}) - $signed({1'b0, bus.game_state[5:3]});
    assign dc_p0 = $signed({1'b0, bus.cursor[2:0]}) - $signed({1'b0, bus.game_state[2:0]});

    always_comb begin
        prim_p0   = try_step(bus.game_state, 4'sd0, unit_dir(dc_p0));
        sec_p0    = try_step(bus.game_state, unit_dir(dr_p0), 4'sd0);
        state_p0  = bus.game_state;
        result_p0 = 1'b0;
        if (prim_p0.ok) begin
            state_p0  = prim_p0.st;
            result_p0 = 1'b1;
        end else if (sec_p0.ok) begin
            state_p0  = sec_p0.st;
            result_p0 = 1'b1;
        end
    end

    // ---- stage p1: registered outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1  <= '0;
            result_p1 <= 1'b0;
        end else begin
            state_p1  <= state_p0;
            result_p1 <= result_p0;
        end
    end

    assign bus.game_state_next = state_p1;
    assign bus.result          = result_p1;

endmodule

// File: tb/tb_game_man_move.sv
// ---------------------------------------------------------------------------
// tb_game_man_move
// Directed vectors for the Sokoban move engine with hand-computed boards.
// ---------------------------------------------------------------------------
module tb_game_man_move;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    game_man_move_if bus();

    game_man_move dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Row r of a layer sits at bits r*8 +: 8.
    function automatic logic [63:0] rows(input logic [7:0] r0, input logic [7:0] r1,
                                         input logic [7:0] r2, input logic [7:0] r3,
                                         input logic [7:0] r4, input logic [7:0] r5,
                                         input logic [7:0] r6, input logic [7:0] r7);
        return {r7, r6, r5, r4, r3, r2, r1, r0};
    endfunction

    function automatic logic [133:0] pack(input logic [63:0] fl, input logic [63:0] bx,
                                          input logic [2:0] r, input logic [2:0] c);
        return {fl, bx, r, c};
    endfunction

    task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [133:0] st, input logic [2:0] cr,
                        input logic [2:0] cc, input logic [133:0] exp_st, input logic exp_r);
        bus.game_state = st;
        bus.cursor     = {cr, cc};
        @(posedge clk);
        #1;
        check({tag, "_state"}, bus.game_state_next, exp_st);
        check({tag, "_result"}, {133'b0, bus.result}, {133'b0, exp_r});
    endtask

    logic [63:0] fl_c, fl_p, bx_p, fl_p2, bx_p2, fl_e, fl_w, bx_w;
    logic [63:0] fl_g, bx_g, fl_l, bx_l, fl_i;

    initial begin
        fl_c  = rows(8'h00, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h00);
        fl_p  = rows(8'h00, 8'h56, 8'h7E, 8'h56, 8'h7E, 8'h56, 8'h7E, 8'h00);
        bx_p  = rows(8'h00, 8'h28, 8'h00, 8'h28, 8'h00, 8'h28, 8'h00, 8'h00);
        fl_p2 = rows(8'h00, 8'h4E, 8'h7E, 8'h56, 8'h7E, 8'h56, 8'h7E, 8'h00);
        bx_p2 = rows(8'h00, 8'h30, 8'h00, 8'h28, 8'h00, 8'h28, 8'h00, 8'h00);
        fl_e  = rows(8'h03, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
        fl_w  = rows(8'h00, 8'h3E, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        bx_w  = rows(8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        fl_g  = rows(8'h00, 8'h40, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        bx_g  = rows(8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        fl_l  = rows(8'h80, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        bx_l  = rows(8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        fl_i  = rows(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08);

        rst            = 1'b1;
        bus.game_state = pack(fl_c, 64'h0, 3'd1, 3'd1);
        bus.cursor     = {3'd2, 3'd7};
        #12;
        check("reset_state", bus.game_state_next, 134'h0);
        check("reset_result", {133'b0, bus.result}, 134'h0);
        @(negedge clk);
        rst = 1'b0;

        // Corridor: right, then vertical fallback, then stuck.
        step("cor1", pack(fl_c, 64'h0, 3'd1, 3'd1), 3'd2, 3'd7, pack(fl_c, 64'h0, 3'd1, 3'd2), 1'b1);
        step("cor2", pack(fl_c, 64'h0, 3'd1, 3'd2), 3'd2, 3'd7, pack(fl_c, 64'h0, 3'd2, 3'd2), 1'b1);
        step("cor3", pack(fl_c, 64'h0, 3'd2, 3'd2), 3'd2, 3'd7, pack(fl_c, 64'h0, 3'd2, 3'd2), 1'b0);
        step("cor_up", pack(fl_c, 64'h0, 3'd2, 3'd2), 3'd1, 3'd2, pack(fl_c, 64'h0, 3'd1, 3'd2), 1'b1);

        // Asynchronous reset in mid-cycle, output held at zero until the next edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", bus.game_state_next, 134'h0);
        check("async_rst_result", {133'b0, bus.result}, 134'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_hold_state", bus.game_state_next, 134'h0);

        // Push sequence.
        step("push1", pack(fl_p, bx_p, 3'd1, 3'd1), 3'd2, 3'd7, pack(fl_p, bx_p, 3'd1, 3'd2), 1'b1);
        step("push2", pack(fl_p, bx_p, 3'd1, 3'd2), 3'd2, 3'd7, pack(fl_p2, bx_p2, 3'd1, 3'd3), 1'b1);
        step("push3", pack(fl_p2, bx_p2, 3'd1, 3'd3), 3'd2, 3'd7, pack(fl_p2, bx_p2, 3'd2, 3'd3), 1'b1);

        // Edge cases on the grid border.
        step("same_cell", pack(fl_e, 64'h0, 3'd0, 3'd0), 3'd0, 3'd0, pack(fl_e, 64'h0, 3'd0, 3'd0), 1'b0);
        step("edge_left", pack(fl_e, 64'h0, 3'd0, 3'd1), 3'd7, 3'd0, pack(fl_e, 64'h0, 3'd0, 3'd0), 1'b1);
        step("edge_down", pack(fl_e, 64'h0, 3'd0, 3'd0), 3'd7, 3'd0, pack(fl_e, 64'h0, 3'd1, 3'd0), 1'b1);

        // Box blocked by wall: no move when no fallback, fallback down otherwise.
        step("wall_r0", pack(fl_w, bx_w, 3'd1, 3'd5), 3'd1, 3'd7, pack(fl_w, bx_w, 3'd1, 3'd5), 1'b0);
        step("wall_fb", pack(fl_w, bx_w, 3'd1, 3'd5), 3'd2, 3'd7, pack(fl_w, bx_w, 3'd2, 3'd5), 1'b1);

        // Box blocked by grid edge; wrapped cells are floor so wrap-around would push.
        step("grid_right", pack(fl_g, bx_g, 3'd1, 3'd6), 3'd1, 3'd7, pack(fl_g, bx_g, 3'd1, 3'd6), 1'b0);
        step("grid_left", pack(fl_l, bx_l, 3'd1, 3'd1), 3'd1, 3'd0, pack(fl_l, bx_l, 3'd1, 3'd1), 1'b0);

        // Isolated man: state echoed.
        step("isolated", pack(fl_i, 64'h0, 3'd7, 3'd3), 3'd7, 3'd7, pack(fl_i, 64'h0, 3'd7, 3'd3), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
